mul_hash_pipe: RTL
==================

# mul_hash_pipe

Parametrised, flow-controlled multiplicative hash unit for the fast-pattern-matcher front end. Each accepted input symbol is multiplied by a fixed odd constant split into NTERM partial products, which are output separately for downstream shift-and-add hashing. The products are also combined into a Fibonacci-style hash: the top bits of the low product word. A valid/ready handshake and an opaque tag path let it sit directly between a byte-stream FIFO and the hash-table lookup stage.

## Interface

Parameters:
- DATA_W, 8, input symbol width.
- CHUNK, 16, width of each constant slice.
- NTERM, 4, number of slices; constant width B_W = NTERM*CHUNK.
- MULT, 64'h0b4e0ef37bc32127, hash constant; only bits [B_W-1:0] are used.
- HASH_BITS, 16, combined hash width; range 1..B_W.
- IN_REGS, 1, input register stages before the multiply; range 1..4.
- TAG_W, 8, sideband tag width, carried unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: one clock; synchronous, active-high.
- in_data  in  DATA_W  symbol.
- in_tag  in  TAG_W  sideband tag.
- in_valid  in  1  input valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_terms  out  NTERM*(DATA_W+CHUNK)  term i at [i*(DATA_W+CHUNK) +: DATA_W+CHUNK].
- out_hash  out  HASH_BITS  combined hash.
- out_tag  out  TAG_W  tag of the same transaction.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.

## Operation

- Pipeline depth is L = IN_REGS + 2 stages:
  - IN_REGS input stages holding data, tag and valid.
  - Multiply stage, which registers term_i = a * MULT[i*CHUNK +: CHUNK] for each i. Terms are unsigned and exact at DATA_W+CHUNK bits.
  - Combine/output stage, which registers the terms, the tag, and hash = (sum_i term_i << (i*CHUNK)) mod 2^B_W, then [B_W-1 -: HASH_BITS]. This equals (a*MULT mod 2^B_W) >> (B_W-HASH_BITS).
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads in_valid && in_ready together with its data and tag.
  - When adv=0, every register (data, tag, valid) holds.
- Bubbles are not collapsed. An invalid slot advances like a valid one, and its data is don't-care internally.
- out_terms, out_hash and out_tag are meaningful only when out_valid=1. They remain stable while out_valid && !out_ready.
- Reset clears every valid bit and every data and tag register to 0. Outputs after reset: out_valid=0, out_hash=0, out_terms=0, out_tag=0, in_ready=1 (combinationally, since out_valid=0).
- A reset asserted mid-stream discards all in-flight transactions. Nothing accepted before the reset cycle appears at the output afterwards.
- No state machine beyond the valid shift chain. No counters are exposed.

## Timing

- Latency with no backpressure: a transaction accepted at edge t appears with out_valid=1 after edge t+L-1, i.e. L cycles. With defaults L=3.
- Throughput is one transaction per cycle while out_ready=1.
- Each cycle out_ready=0 with out_valid=1 adds exactly one cycle of latency to every in-flight transaction.
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the output transfer and the input acceptance both occur.
- Capacity is L transactions; no transaction is dropped or duplicated under any out_ready pattern.
- Multiply and combine may be split over LUT adders, but the register stages are exactly as listed. No DSP inference is required.

## Test plan

- Reset then single transaction (defaults), in_data=0x01, tag=0x5A. out_valid rises 3 cycles after acceptance with:
  - terms = 0x002127, 0x007bc3, 0x000ef3, 0x000b4e (i=0..3);
  - hash = 0x0b4e, tag = 0x5A.
- in_data=0xFF:
  - term0 = 0x2105D9;
  - hash = 0x42c0, the top 16 bits of 255*MULT mod 2^64.
- Streaming 0x00..0xFF back-to-back with out_ready=1: 256 outputs in order, one per cycle, each matching the reference model; in_ready stays 1.
- Backpressure: stream 6 inputs, drop out_ready for 4 cycles once the first output is valid.
  - in_ready=0 during the stall.
  - Outputs hold stable.
  - All 6 emerge in order with no loss or duplication.
  - Randomised out_ready/in_valid run of 10k transactions checks against a scoreboard.
- Reset mid-stream: rst asserted with 3 transactions in flight. The next cycle shows out_valid=0 and all outputs at 0, and none of the old transactions ever appear.
- Parameter sweep with NTERM=2, CHUNK=32, HASH_BITS=12, IN_REGS=3:
  - latency is 5;
  - the hash equals the top 12 bits of (a*MULT[63:0]) mod 2^64 for random a.

Source files
------------

// File: rtl/mul_hash_if.sv
// Handshake bundle for the multiplicative hash unit: the upstream symbol side
// and the downstream terms/hash side share one interface instance.
interface mul_hash_if #(
  parameter int DATA_W    = 8,
  parameter int CHUNK     = 16,
  parameter int NTERM     = 4,
  parameter int HASH_BITS = 16,
  parameter int TAG_W     = 8
);
  logic [DATA_W-1:0]               in_data;
  logic [TAG_W-1:0]                in_tag;
  logic                            in_valid;
  logic                            in_ready;
  logic [NTERM*(DATA_W+CHUNK)-1:0] out_terms;
  logic [HASH_BITS-1:0]            out_hash;
  logic [TAG_W-1:0]                out_tag;
  logic                            out_valid;
  logic                            out_ready;

  // Environment side: produces symbols, consumes hashes.
  modport master (
    output in_data, in_tag, in_valid, out_ready,
    input  in_ready, out_terms, out_hash, out_tag, out_valid
  );

  // Hash unit side.
  modport slave (
    input  in_data, in_tag, in_valid, out_ready,
    output in_ready, out_terms, out_hash, out_tag, out_valid
  );
endinterface

// File: rtl/mul_hash_pipe.sv
// Flow-controlled multiplicative hash: IN_REGS input stages, a partial-product
// multiply stage and a combine stage that emits the terms plus the top
// HASH_BITS of (a*MULT mod 2^B_W). All stages advance together.
module mul_hash_pipe #(
  parameter int          DATA_W    = 8,
  parameter int          CHUNK     = 16,
  parameter int          NTERM     = 4,
  parameter logic [63:0] MULT      = 64'h0b4e0ef37bc32127,
  parameter int          HASH_BITS = 16,
  parameter int          IN_REGS   = 1,
  parameter int          TAG_W     = 8
) (
  input logic     clk,
  input logic     rst,
  mul_hash_if.slave bus
);
  localparam int B_W    = NTERM * CHUNK;
  localparam int TERM_W = DATA_W + CHUNK;
  localparam logic [B_W-1:0] MULT_B = B_W'(MULT);

  // Fibonacci hash: keep the most significant HASH_BITS of the low product word.
  function automatic logic [HASH_BITS-1:0] take_hash(input logic [B_W-1:0] s);
    return s[B_W-1 -: HASH_BITS];
  endfunction

  logic adv;

  logic [DATA_W-1:0] dat_p0 [IN_REGS];
  logic [TAG_W-1:0]  tag_p0 [IN_REGS];
  logic [IN_REGS-1:0] vld_p0;

  logic [TERM_W-1:0] term_p1 [NTERM];
  logic [TAG_W-1:0]  tag_p1;
  logic              vld_p1;

  logic [B_W-1:0]    sum_c;

  logic [NTERM*TERM_W-1:0] terms_p2;
  logic [HASH_BITS-1:0]    hash_p2;
  logic [TAG_W-1:0]        tag_p2;
  logic                    vld_p2;

  // A stalled output freezes the whole chain; bubbles move like data.
  assign adv          = !vld_p2 || bus.out_ready;
  assign bus.in_ready = adv;

  // ---- stage p0: input register chain ----
  // Shift symbol, tag and valid through the IN_REGS input stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IN_REGS; i++) begin
        dat_p0[i] <= '0;
        tag_p0[i] <= '0;
      end
      vld_p0 <= '0;
    end else if (adv) begin
      dat_p0[0] <= bus.in_data;
      tag_p0[0] <= bus.in_tag;
      vld_p0[0] <= bus.in_valid && adv;
      for (int i = 1; i < IN_REGS; i++) begin
        dat_p0[i] <= dat_p0[i-1];
        tag_p0[i] <= tag_p0[i-1];
        vld_p0[i] <= vld_p0[i-1];
      end
    end
  end

  // ---- stage p1: partial products against each constant slice ----
  // Each term is exact at DATA_W+CHUNK bits, so no truncation happens here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTERM; i++) term_p1[i] <= '0;
      tag_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < NTERM; i++)
        term_p1[i] <= TERM_W'(dat_p0[IN_REGS-1]) * TERM_W'(MULT_B[i*CHUNK +: CHUNK]);
      tag_p1 <= tag_p0[IN_REGS-1];
      vld_p1 <= vld_p0[IN_REGS-1];
    end
  end

  // Shift-and-add the terms back into the low B_W bits of the full product.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NTERM; i++)
      sum_c = sum_c + (B_W'(term_p1[i]) << (i * CHUNK));
  end

  // ---- stage p2: combine / output register ----
  // Register the terms, the combined hash and the tag for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      terms_p2 <= '0;
      hash_p2  <= '0;
      tag_p2   <= '0;
      vld_p2   <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < NTERM; i++)
        terms_p2[i*TERM_W +: TERM_W] <= term_p1[i];
      hash_p2 <= take_hash(sum_c);
      tag_p2  <= tag_p1;
      vld_p2  <= vld_p1;
    end
  end

  assign bus.out_terms = terms_p2;
  assign bus.out_hash  = hash_p2;
  assign bus.out_tag   = tag_p2;
  assign bus.out_valid = vld_p2;
endmodule
